// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and the debug/loader port.
// Define DMEM_ARB_AGING_EN to enable the loader aging counter and starvation override.
module dmem_arbiter #(
    parameter int AW       = 3,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic          p_gnt,
    output logic          p_stall,
    output logic          p_rvalid,
    output logic [DW-1:0] p_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD_P, RD_D} state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    state_t state, state_nxt;
    acc_t   win;

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

`ifdef DMEM_ARB_AGING_EN
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       aged;

    assign aged = (wait_cnt == MAX_W);

    // Pipeline has priority on conflict until the loader has been refused MAX_WAIT times.
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (p_req && d_req) begin
                if (aged) d_gnt = 1'b1;
                else      p_gnt = 1'b1;
            end else begin
                p_gnt = p_req;
                d_gnt = d_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (!d_req || d_gnt)
            wait_cnt <= '0;
        else if (!aged)
            wait_cnt <= wait_cnt + 4'd1;
    end

    assign p_stall = rst_n & p_req & ~p_gnt;
`else
    // Strict pipeline priority: the loader only gets idle pipeline cycles.
    always_comb begin
        p_gnt = rst_n & p_req;
        d_gnt = rst_n & d_req & ~p_req;
    end

    assign p_stall = 1'b0;
`endif

    always_comb begin
        win = '0;
        if (p_gnt)
            win = '{we: p_we, addr: p_addr, wdata: p_wdata};
        else if (d_gnt)
            win = '{we: d_we, addr: d_addr, wdata: d_wdata};
    end

    assign mem_en    = p_gnt | d_gnt;
    assign mem_we    = win.we;
    assign mem_addr  = win.addr;
    assign mem_wdata = win.wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The state names whose read returns in the next cycle; a new grant overlaps that return.
    always_comb begin
        state_nxt = IDLE;
        if (p_gnt && !p_we)
            state_nxt = RD_P;
        else if (d_gnt && !d_we)
            state_nxt = RD_D;
    end

    // Gated by rst_n so a read granted just before reset never reports valid.
    assign p_rvalid = rst_n && (state == RD_P);
    assign d_rvalid = rst_n && (state == RD_D);
    assign p_rdata  = p_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, aging sequence, then randomized traffic
// checked against a request-level reference model with its own copy of memory.
module tb_dmem_arbiter;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int MW = 4;
`ifdef DMEM_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          p_req, p_we, p_gnt, p_stall, p_rvalid;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata, p_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Environment: the 8x16 single-port memory with registered read data.
    logic [DW-1:0] mem_arr [8] = '{default: '0};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_arr[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_arr[mem_addr];
        end
    end

    typedef struct {
        logic          r, pr, pw;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        bit            has_exp;
        logic          pg, dg, pst, rvp, rvd;
        logic [DW-1:0] rd;
        logic [AW-1:0] ma;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int            wcnt = 0;
    bit            pend_v = 0;
    bit            pend_d = 0;
    logic [DW-1:0] pend_data = '0;
    logic [DW-1:0] ref_mem [8] = '{default: '0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, pr, pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                                input logic dr, dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                                input logic pg, dg, rvp, rvd, input logic [DW-1:0] rd,
                                input logic [AW-1:0] ma);
        vec_t v;
        v = '{r: r, pr: pr, pw: pw, pa: pa, pd: pd, dr: dr, dw: dw, da: da, dd: dd,
              has_exp: 1'b1, pg: pg, dg: dg, pst: 1'b0, rvp: rvp, rvd: rvd, rd: rd, ma: ma};
        return v;
    endfunction

    // One clock cycle: drive at negedge, check at negedge+1, advance the model.
    task automatic cycle(input vec_t v, output logic gp, output logic gd);
        logic          e_en, e_we, e_st, e_rvp, e_rvd;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd;
        rst_n = v.r;
        p_req = v.pr; p_we = v.pw; p_addr = v.pa; p_wdata = v.pd;
        d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dd;
        #1;
        gp = 1'b0; gd = 1'b0;
        if (v.r) begin
            if (v.pr && v.dr) begin
                if (AGING && wcnt == MW) gd = 1'b1;
                else                     gp = 1'b1;
            end else begin
                gp = v.pr; gd = v.dr;
            end
        end
        e_en  = gp | gd;
        e_we  = gp ? v.pw : (gd ? v.dw : 1'b0);
        e_a   = gp ? v.pa : (gd ? v.da : '0);
        e_wd  = gp ? v.pd : (gd ? v.dd : '0);
        e_st  = AGING && v.r && v.pr && !gp;
        e_rvp = v.r && pend_v && !pend_d;
        e_rvd = v.r && pend_v && pend_d;
        chk("p_gnt", 32'(p_gnt), 32'(gp));
        chk("d_gnt", 32'(d_gnt), 32'(gd));
        chk("p_stall", 32'(p_stall), 32'(e_st));
        chk("mem_ctl", 32'({mem_en, mem_we}), 32'({e_en, e_we}));
        chk("mem_addr", 32'(mem_addr), 32'(e_a));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        chk("rvalid", 32'({p_rvalid, d_rvalid}), 32'({e_rvp, e_rvd}));
        chk("p_rdata", 32'(p_rdata), e_rvp ? 32'(pend_data) : 32'h0);
        chk("d_rdata", 32'(d_rdata), e_rvd ? 32'(pend_data) : 32'h0);
        if (v.has_exp) begin
            chk("vec_gnt", 32'({p_gnt, d_gnt}), 32'({v.pg, v.dg}));
            chk("vec_stall", 32'(p_stall), 32'(v.pst));
            chk("vec_rvalid", 32'({p_rvalid, d_rvalid}), 32'({v.rvp, v.rvd}));
            chk("vec_rdata", 32'({p_rdata, d_rdata}),
                32'({(v.rvp ? v.rd : 16'h0), (v.rvd ? v.rd : 16'h0)}));
            chk("vec_mem_addr", 32'(mem_addr), 32'(v.ma));
        end
        if (!v.r) begin
            wcnt = 0; pend_v = 0;
        end else begin
            if (v.dr && !gd) wcnt = (wcnt < MW) ? wcnt + 1 : MW;
            else             wcnt = 0;
            pend_v    = e_en && !e_we;
            pend_d    = gd;
            pend_data = ref_mem[e_a];
            if (e_en && e_we) ref_mem[e_a] = e_wd;
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        logic gp, gd, pgl, dgl;
        logic prev_p, prev_d;

        rst_n = 0; p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        @(negedge clk);

        //            r pr pw pa pd       dr dw da dd       pg dg rvp rvd rd       ma
        tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 0, 6, 16'h0,    0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 0, 6, 16'h0,    0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk(0, 1, 0, 0, 16'h0,    1, 0, 6, 16'h0,    0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk(1, 1, 1, 5, 16'hBEEF, 1, 0, 6, 16'h0,    1, 0, 0, 0, 16'h0,    5));
        tbl.push_back(mk(1, 1, 1, 1, 16'h1111, 0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0,    1));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0,    1, 1, 2, 16'h2222, 0, 1, 0, 0, 16'h0,    2));
        tbl.push_back(mk(1, 1, 0, 5, 16'h0,    0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0,    5));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 1, 0, 16'hBEEF, 0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0,    1, 1, 3, 16'h1234, 0, 1, 0, 0, 16'h0,    3));
        tbl.push_back(mk(1, 1, 0, 3, 16'h0,    0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0,    3));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0,    1, 0, 2, 16'h0,    0, 1, 1, 0, 16'h1234, 2));
        tbl.push_back(mk(1, 1, 0, 1, 16'h0,    0, 0, 0, 16'h0,    1, 0, 0, 1, 16'h2222, 1));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0,    1, 0, 2, 16'h0,    0, 1, 1, 0, 16'h1111, 2));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 1, 16'h2222, 0));
        // read granted, then reset: the read must never return
        tbl.push_back(mk(1, 1, 0, 5, 16'h0,    0, 0, 0, 16'h0,    1, 0, 0, 0, 16'h0,    5));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 0, 0, 16'h0,    0));
        foreach (tbl[i]) cycle(tbl[i], gp, gd);

        // Continuous conflict: reads of addr 0 (p) and addr 4 (d), both still zero.
        prev_p = 0; prev_d = 0;
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                dgl = AGING && (i % (MW + 1) == MW);
                pgl = !dgl;
            end else begin
                pgl = 0; dgl = 1;
            end
            v = mk(1, (i < 10), 0, 0, 16'h0, 1, 0, 4, 16'h0,
                   pgl, dgl, prev_p, prev_d, 16'h0, dgl ? 3'd4 : 3'd0);
            v.pst = AGING && dgl && (i < 10);
            cycle(v, gp, gd);
            prev_p = pgl; prev_d = dgl;
        end

        // Randomized traffic; a refused requester holds its request stable.
        v = mk(1, 0, 0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0);
        v.has_exp = 0;
        gp = 0; gd = 0;
        for (int i = 0; i < 600; i++) begin
            v.r = ($urandom_range(0, 49) != 0);
            if (!(v.pr && !gp && v.r)) begin
                v.pr = ($urandom_range(0, 3) != 0);
                v.pw = $urandom_range(0, 1) == 1;
                v.pa = AW'($urandom_range(0, 7));
                v.pd = DW'($urandom);
            end
            if (!(v.dr && !gd && v.r)) begin
                v.dr = ($urandom_range(0, 2) != 0);
                v.dw = $urandom_range(0, 1) == 1;
                v.da = AW'($urandom_range(0, 7));
                v.dd = DW'($urandom);
            end
            cycle(v, gp, gd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
